// File: rtl/ahblite_busmatrix_pkg.sv
// Shared bus-matrix definitions: AHB transfer encodings, response codes and
// the address-phase bundle used by the input and output stages.
package ahblite_busmatrix_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Address-phase fields that must survive a stall. HTRANS is not kept:
  // a held transfer is always re-presented as NONSEQ.
  typedef struct packed {
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
  } addr_phase_t;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic trans_is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahblite_busmatrix_inputstage.sv
// Bus-matrix input stage: registers a master's address phase when no output
// stage can take it immediately, and stalls the master until it is accepted.
module ahblite_busmatrix_inputstage
  import ahblite_busmatrix_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        HSEL_IS,
  output logic [31:0] HADDR_IS,
  output logic [1:0]  HTRANS_IS,
  output logic        HWRITE_IS,
  output logic [2:0]  HSIZE_IS,
  output logic [2:0]  HBURST_IS,
  output logic [3:0]  HPROT_IS,
  output logic        TRANS_HOLD,
  input  logic        ACTIVE_OS,
  input  logic        HREADY_OS,
  input  logic        HREADYOUT_DEC,
  input  logic        HRESP_DEC
);

  addr_phase_t live_ap;
  addr_phase_t hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic        data_phase_q, data_phase_d;
  logic        new_trans;
  logic        accepted;

  assign live_ap = '{hsel: HSEL, haddr: HADDR, hwrite: HWRITE,
                     hsize: HSIZE, hburst: HBURST, hprot: HPROT};

  assign new_trans = HSEL & trans_is_active(HTRANS) & HREADY;
  assign accepted  = ACTIVE_OS & HREADY_OS;

  // Next-state for the hold register and the data-phase tracker.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and infers a latch.
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    data_phase_d = data_phase_q;

    // Acceptance wins: a held transfer is released; a live one never needs
    // holding. While holding, HREADYOUT=0 keeps new_trans low.
    if (accepted) begin
      hold_valid_d = 1'b0;
    end else if (new_trans) begin
      hold_valid_d = 1'b1;
      hold_d       = live_ap;
    end

    // An acceptance always opens a data phase, even when the previous one
    // completes on the same edge, so back-to-back transfers see no bubble.
    if (accepted) begin
      data_phase_d = 1'b1;
    end else if (HREADYOUT_DEC) begin
      data_phase_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_valid_q <= 1'b0;
      data_phase_q <= 1'b0;
      // NOTE: the hold payload is reset too, although it is only observed
      // while hold_valid_q=1; this keeps it free of X after reset.
      hold_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      hold_valid_q <= hold_valid_d;
      data_phase_q <= data_phase_d;
      hold_d_load();
    end
  end

  // Split out so the payload load reads as a single intent in the block above.
  task automatic hold_d_load();
    hold_q <= hold_d;
  endtask

  // Address phase to the output stages: held copy while stalled, live otherwise.
  always_comb begin
    if (hold_valid_q) begin
      HSEL_IS   = hold_q.hsel;
      HADDR_IS  = hold_q.haddr;
      HTRANS_IS = HTRANS_NONSEQ;
      HWRITE_IS = hold_q.hwrite;
      HSIZE_IS  = hold_q.hsize;
      HBURST_IS = hold_q.hburst;
      HPROT_IS  = hold_q.hprot;
    end else begin
      HSEL_IS   = HSEL;
      HADDR_IS  = HADDR;
      HTRANS_IS = HTRANS;
      HWRITE_IS = HWRITE;
      HSIZE_IS  = HSIZE;
      HBURST_IS = HBURST;
      HPROT_IS  = HPROT;
    end
  end

  // Master-side handshake: stall while holding, otherwise reflect the slave
  // during a data phase.
  always_comb begin
    if (hold_valid_q) begin
      HREADYOUT = 1'b0;
    end else if (data_phase_q) begin
      HREADYOUT = HREADYOUT_DEC;
    end else begin
      HREADYOUT = 1'b1;
    end
    HRESP      = data_phase_q ? HRESP_DEC : HRESP_OKAY;
    TRANS_HOLD = hold_valid_q | new_trans;
  end

endmodule

// File: tb/tb_ahblite_busmatrix_inputstage.sv
// Directed bench for the bus-matrix input stage. Each vector is driven just
// after a rising edge and its hand-computed expected outputs are queued; a
// monitor pops and compares on the following falling edge.
module tb_ahblite_busmatrix_inputstage;
  import ahblite_busmatrix_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = '0;
  logic [2:0]  HBURST = '0;
  logic [3:0]  HPROT = '0;
  logic        HREADY = 1'b1;
  logic        HREADYOUT, HRESP;
  logic        HSEL_IS, HWRITE_IS, TRANS_HOLD;
  logic [31:0] HADDR_IS;
  logic [1:0]  HTRANS_IS;
  logic [2:0]  HSIZE_IS, HBURST_IS;
  logic [3:0]  HPROT_IS;
  logic        ACTIVE_OS = 1'b0;
  logic        HREADY_OS = 1'b0;
  logic        HREADYOUT_DEC = 1'b1;
  logic        HRESP_DEC = 1'b0;

  ahblite_busmatrix_inputstage dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HSEL_IS(HSEL_IS), .HADDR_IS(HADDR_IS), .HTRANS_IS(HTRANS_IS),
    .HWRITE_IS(HWRITE_IS), .HSIZE_IS(HSIZE_IS), .HBURST_IS(HBURST_IS),
    .HPROT_IS(HPROT_IS), .TRANS_HOLD(TRANS_HOLD), .ACTIVE_OS(ACTIVE_OS),
    .HREADY_OS(HREADY_OS), .HREADYOUT_DEC(HREADYOUT_DEC), .HRESP_DEC(HRESP_DEC)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        rst_n, sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size, burst;
    logic [3:0]  prot;
    logic        rdy, act, hos, drdy, dresp;
  } stim_t;

  typedef struct {
    int          idx;
    logic        rdy, resp, th, sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size, burst;
    logic [3:0]  prot;
  } exp_t;

  exp_t exp_q[$];
  int   vectors_applied = 0;
  int   miscompares = 0;
  int   vec_idx = 0;

  function automatic stim_t mk_s(logic rst_n, logic sel, logic [31:0] addr,
                                 logic [1:0] trans, logic wr, logic [2:0] size,
                                 logic [2:0] burst, logic [3:0] prot, logic rdy,
                                 logic act, logic hos, logic drdy, logic dresp);
    stim_t s;
    s.rst_n = rst_n; s.sel = sel; s.addr = addr; s.trans = trans; s.wr = wr;
    s.size = size; s.burst = burst; s.prot = prot; s.rdy = rdy; s.act = act;
    s.hos = hos; s.drdy = drdy; s.dresp = dresp;
    return s;
  endfunction

  function automatic exp_t mk_e(logic rdy, logic resp, logic th, logic sel,
                                logic [31:0] addr, logic [1:0] trans, logic wr,
                                logic [2:0] size, logic [2:0] burst, logic [3:0] prot);
    exp_t e;
    e.idx = 0; e.rdy = rdy; e.resp = resp; e.th = th; e.sel = sel; e.addr = addr;
    e.trans = trans; e.wr = wr; e.size = size; e.burst = burst; e.prot = prot;
    return e;
  endfunction

  task automatic apply(input stim_t s, input exp_t e);
    @(posedge HCLK);
    #1;
    HRESETn = s.rst_n; HSEL = s.sel; HADDR = s.addr; HTRANS = s.trans;
    HWRITE = s.wr; HSIZE = s.size; HBURST = s.burst; HPROT = s.prot;
    HREADY = s.rdy; ACTIVE_OS = s.act; HREADY_OS = s.hos;
    HREADYOUT_DEC = s.drdy; HRESP_DEC = s.dresp;
    vec_idx++;
    e.idx = vec_idx;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act_v, input logic [31:0] exp_v);
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL v%0d %s: got 0x%0h, expected 0x%0h", idx, name, act_v, exp_v);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge HCLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors_applied++;
      check("HREADYOUT",  e.idx, 32'(HREADYOUT),  32'(e.rdy));
      check("HRESP",      e.idx, 32'(HRESP),      32'(e.resp));
      check("TRANS_HOLD", e.idx, 32'(TRANS_HOLD), 32'(e.th));
      check("HSEL_IS",    e.idx, 32'(HSEL_IS),    32'(e.sel));
      check("HADDR_IS",   e.idx, HADDR_IS,        e.addr);
      check("HTRANS_IS",  e.idx, 32'(HTRANS_IS),  32'(e.trans));
      check("HWRITE_IS",  e.idx, 32'(HWRITE_IS),  32'(e.wr));
      check("HSIZE_IS",   e.idx, 32'(HSIZE_IS),   32'(e.size));
      check("HBURST_IS",  e.idx, 32'(HBURST_IS),  32'(e.burst));
      check("HPROT_IS",   e.idx, 32'(HPROT_IS),   32'(e.prot));
    end
  end

  localparam logic [1:0] ID = HTRANS_IDLE;
  localparam logic [1:0] BY = HTRANS_BUSY;
  localparam logic [1:0] NS = HTRANS_NONSEQ;
  localparam logic [1:0] SQ = HTRANS_SEQ;
  localparam logic       OK = HRESP_OKAY;
  localparam logic       ER = HRESP_ERROR;

  initial begin
    // Reset held, then released with an idle master.
    apply(mk_s(0,1,32'h55,ID,0,2,0,3, 1,0,0,1,0), mk_e(1,OK,0, 1,32'h55,ID,0,2,0,3));
    apply(mk_s(1,1,32'h55,ID,0,2,0,3, 1,0,0,1,0), mk_e(1,OK,0, 1,32'h55,ID,0,2,0,3));

    // NONSEQ read accepted in its own address cycle: no hold, live pass-through.
    apply(mk_s(1,1,32'h100,NS,0,2,0,3, 1,1,1,1,0), mk_e(1,OK,1, 1,32'h100,NS,0,2,0,3));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,0,0),   mk_e(0,OK,0, 0,32'h0,ID,0,0,0,0));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,1,0),   mk_e(1,OK,0, 0,32'h0,ID,0,0,0,0));

    // NONSEQ write stalled three cycles; held copy shown despite changing inputs.
    apply(mk_s(1,1,32'h200,NS,1,2,0,3, 1,0,0,1,0), mk_e(1,OK,1, 1,32'h200,NS,1,2,0,3));
    apply(mk_s(1,0,32'hDEAD_0000,ID,0,0,0,0, 0,0,0,1,0), mk_e(0,OK,1, 1,32'h200,NS,1,2,0,3));
    apply(mk_s(1,0,32'hDEAD_0000,ID,0,0,0,0, 0,0,0,1,0), mk_e(0,OK,1, 1,32'h200,NS,1,2,0,3));
    apply(mk_s(1,0,32'hDEAD_0000,ID,0,0,0,0, 0,1,1,1,0), mk_e(0,OK,1, 1,32'h200,NS,1,2,0,3));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,0,0),   mk_e(0,OK,0, 0,32'h0,ID,0,0,0,0));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,1,0),   mk_e(1,OK,0, 0,32'h0,ID,0,0,0,0));

    // SEQ beat held one cycle: re-presented as NONSEQ with original burst/size.
    apply(mk_s(1,1,32'h304,SQ,0,2,3,3, 1,0,0,1,0), mk_e(1,OK,1, 1,32'h304,SQ,0,2,3,3));
    apply(mk_s(1,1,32'h308,SQ,0,0,1,3, 0,1,1,1,0), mk_e(0,OK,1, 1,32'h304,NS,0,2,3,3));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,1,0),   mk_e(1,OK,0, 0,32'h0,ID,0,0,0,0));

    // Back-to-back NONSEQ 0x0/0x4: data phase persists through the overlap.
    apply(mk_s(1,1,32'h0,NS,0,2,0,3, 1,1,1,1,0),   mk_e(1,OK,1, 1,32'h0,NS,0,2,0,3));
    apply(mk_s(1,1,32'h4,NS,0,2,0,3, 1,1,1,1,0),   mk_e(1,OK,1, 1,32'h4,NS,0,2,0,3));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,0,0),   mk_e(0,OK,0, 0,32'h0,ID,0,0,0,0));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,1,0),   mk_e(1,OK,0, 0,32'h0,ID,0,0,0,0));

    // IDLE and BUSY with HSEL=1 are never captured.
    apply(mk_s(1,1,32'h400,ID,1,2,0,3, 1,0,0,1,0), mk_e(1,OK,0, 1,32'h400,ID,1,2,0,3));
    apply(mk_s(1,1,32'h404,BY,1,2,0,3, 1,0,0,1,0), mk_e(1,OK,0, 1,32'h404,BY,1,2,0,3));

    // Error response only visible during the data phase.
    apply(mk_s(1,1,32'h500,NS,0,2,0,3, 1,1,1,1,1), mk_e(1,OK,1, 1,32'h500,NS,0,2,0,3));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,0,1),   mk_e(0,ER,0, 0,32'h0,ID,0,0,0,0));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,1,1),   mk_e(1,ER,0, 0,32'h0,ID,0,0,0,0));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,1,1),   mk_e(1,OK,0, 0,32'h0,ID,0,0,0,0));

    // Reset mid-hold clears the stall asynchronously.
    apply(mk_s(1,1,32'h600,NS,1,2,0,3, 1,0,0,1,0), mk_e(1,OK,1, 1,32'h600,NS,1,2,0,3));
    apply(mk_s(0,0,32'h0,ID,0,0,0,0, 0,0,0,1,0),   mk_e(1,OK,0, 0,32'h0,ID,0,0,0,0));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,1,0),   mk_e(1,OK,0, 0,32'h0,ID,0,0,0,0));

    // Reset mid-data-phase discards the pending response.
    apply(mk_s(1,1,32'h700,NS,0,2,0,3, 1,1,1,1,0), mk_e(1,OK,1, 1,32'h700,NS,0,2,0,3));
    apply(mk_s(0,0,32'h0,ID,0,0,0,0, 1,0,0,0,1),   mk_e(1,OK,0, 0,32'h0,ID,0,0,0,0));
    apply(mk_s(1,0,32'h0,ID,0,0,0,0, 1,0,0,0,1),   mk_e(1,OK,0, 0,32'h0,ID,0,0,0,0));

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge HCLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
